// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit frame controller.
// Holds the state encoding, the fixed HDLC byte patterns and the
// CRC-16/X.25 byte update used when HDLC_TX_CRC_EN is defined.
package hdlc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_DATA  = 3'd2,
        S_FCS   = 3'd3,
        S_CLOSE = 3'd4,
        S_ABORT = 3'd5,
        S_GAP   = 3'd6
    } hdlc_tx_state_e;

    localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT = 8'hFF;
    localparam logic [7:0]  HDLC_MARK  = 8'hFF;
    localparam logic [15:0] CRC16_POLY = 16'h8408;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Reflected CRC-16 update over one byte, LSB first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[15:1]} ^ CRC16_POLY;
            end else begin
                c = {1'b0, c[15:1]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/hdlc_tx_ctrl_if.sv
// Host-buffer and serializer handshake bundle for hdlc_tx_ctrl.
// master: host/serializer side, slave: the frame controller.
interface hdlc_tx_ctrl_if #(
    parameter int LW = 9
);
    logic          txen_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          abort_i;
    logic [7:0]    buf_data_i;
    logic          buf_valid_i;
    logic          buf_ready_o;
    logic          byte_req_i;
    logic [7:0]    byte_o;
    logic          byte_vld_o;
    logic          byte_flag_o;
    logic          frame_o;
    logic          abortframe_o;
    logic          txdone_o;
    logic          aborted_o;
    logic          busy_o;

    modport master (
        output txen_i, start_i, len_i, abort_i, buf_data_i, buf_valid_i, byte_req_i,
        input  buf_ready_o, byte_o, byte_vld_o, byte_flag_o, frame_o,
               abortframe_o, txdone_o, aborted_o, busy_o
    );

    modport slave (
        input  txen_i, start_i, len_i, abort_i, buf_data_i, buf_valid_i, byte_req_i,
        output buf_ready_o, byte_o, byte_vld_o, byte_flag_o, frame_o,
               abortframe_o, txdone_o, aborted_o, busy_o
    );
endinterface

// File: rtl/hdlc_crc16.sv
// Registered byte-wide CRC-16/X.25 accumulator. init has priority over en.
module hdlc_crc16
    import hdlc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_d;
    logic [15:0] crc_q;

    // Next CRC value: reload, fold in one byte, or hold.
    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = crc16_update(crc_q, data_i);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit frame controller: answers each serializer byte request
// with idle fill, flags, payload, FCS or the abort pattern.
// Optional feature macro: HDLC_TX_CRC_EN (adds the FCS state and CRC).
module hdlc_tx_ctrl
    import hdlc_pkg::*;
#(
    parameter int MAX_LEN   = 256,
    parameter int GAP_FLAGS = 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    hdlc_tx_ctrl_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = (GAP_FLAGS > 0) ? $clog2(GAP_FLAGS + 1) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_FLAGS);
    // After a closing flag or abort, skip GAP entirely when no gap flags are wanted.
    localparam hdlc_tx_state_e POST_STATE = (GAP_FLAGS > 0) ? S_GAP : S_IDLE;

    hdlc_tx_state_e state_d, state_q;
    logic [LW-1:0]  cnt_d, cnt_q;
    logic [GW-1:0]  gap_d, gap_q;
    logic [7:0]     byte_d, byte_q;
    logic           byte_vld_d, byte_vld_q;
    logic           byte_flag_d, byte_flag_q;
    logic           frame_d, frame_q;
    logic           abortframe_d, abortframe_q;
    logic           txdone_d, txdone_q;
    logic           aborted_d, aborted_q;
    logic           busy_d, busy_q;
    logic           buf_ready_s;
    logic           start_ok_s;
    logic           in_body_s;
    logic           abort_hit_s;

    assign start_ok_s = bus.start_i && bus.txen_i && !bus.abort_i &&
                        (bus.len_i != '0) && (bus.len_i <= LW'(MAX_LEN));
    assign in_body_s  = (state_q == S_OPEN) || (state_q == S_DATA) || (state_q == S_FCS);
    // Host abort, loss of enable, or a payload request the buffer cannot serve.
    assign abort_hit_s = in_body_s &&
                         (bus.abort_i || !bus.txen_i ||
                          ((state_q == S_DATA) && bus.byte_req_i && !bus.buf_valid_i));

`ifdef HDLC_TX_CRC_EN
    logic        fcs_hi_d, fcs_hi_q;
    logic        crc_init_s;
    logic        crc_en_s;
    logic [15:0] crc_s;

    hdlc_crc16 u_crc (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (crc_init_s),
        .en_i    (crc_en_s),
        .data_i  (bus.buf_data_i),
        .crc_o   (crc_s)
    );
`endif

    // Next-state, byte selection and status pulses for each request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        byte_d      = byte_q;
        byte_flag_d = byte_flag_q;
        byte_vld_d  = 1'b0;
        txdone_d    = 1'b0;
        aborted_d   = 1'b0;
        buf_ready_s = 1'b0;
`ifdef HDLC_TX_CRC_EN
        fcs_hi_d    = fcs_hi_q;
        crc_init_s  = 1'b0;
        crc_en_s    = 1'b0;
`endif
        if (abort_hit_s) begin
            if (bus.byte_req_i) begin
                // A coincident request is answered with the abort pattern right away.
                byte_vld_d  = 1'b1;
                byte_d      = HDLC_ABORT;
                byte_flag_d = 1'b1;
                aborted_d   = 1'b1;
                state_d     = POST_STATE;
                gap_d       = GAP_INIT;
            end else begin
                state_d = S_ABORT;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.byte_req_i) begin
                        byte_vld_d  = 1'b1;
                        byte_flag_d = 1'b1;
                        byte_d      = bus.txen_i ? HDLC_FLAG : HDLC_MARK;
                    end else begin
                        byte_vld_d = 1'b0;
                    end
                    if (start_ok_s) begin
                        state_d = S_OPEN;
                        cnt_d   = bus.len_i;
`ifdef HDLC_TX_CRC_EN
                        crc_init_s = 1'b1;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_OPEN: begin
                    if (bus.byte_req_i) begin
                        byte_vld_d  = 1'b1;
                        byte_d      = HDLC_FLAG;
                        byte_flag_d = 1'b1;
                        state_d     = S_DATA;
                    end else begin
                        state_d = S_OPEN;
                    end
                end
                S_DATA: begin
                    if (bus.byte_req_i) begin
                        buf_ready_s = 1'b1;
                        byte_vld_d  = 1'b1;
                        byte_d      = bus.buf_data_i;
                        byte_flag_d = 1'b0;
                        cnt_d       = cnt_q - LW'(1'b1);
`ifdef HDLC_TX_CRC_EN
                        crc_en_s = 1'b1;
                        fcs_hi_d = 1'b0;
                        state_d  = (cnt_q == LW'(1'b1)) ? S_FCS : S_DATA;
`else
                        state_d  = (cnt_q == LW'(1'b1)) ? S_CLOSE : S_DATA;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
`ifdef HDLC_TX_CRC_EN
                S_FCS: begin
                    if (bus.byte_req_i) begin
                        byte_vld_d  = 1'b1;
                        byte_flag_d = 1'b0;
                        byte_d      = fcs_hi_q ? ~crc_s[15:8] : ~crc_s[7:0];
                        fcs_hi_d    = 1'b1;
                        state_d     = fcs_hi_q ? S_CLOSE : S_FCS;
                    end else begin
                        state_d = S_FCS;
                    end
                end
`endif
                S_CLOSE: begin
                    if (bus.byte_req_i) begin
                        byte_vld_d  = 1'b1;
                        byte_d      = HDLC_FLAG;
                        byte_flag_d = 1'b1;
                        txdone_d    = 1'b1;
                        state_d     = POST_STATE;
                        gap_d       = GAP_INIT;
                    end else begin
                        state_d = S_CLOSE;
                    end
                end
                S_ABORT: begin
                    if (bus.byte_req_i) begin
                        byte_vld_d  = 1'b1;
                        byte_d      = HDLC_ABORT;
                        byte_flag_d = 1'b1;
                        aborted_d   = 1'b1;
                        state_d     = POST_STATE;
                        gap_d       = GAP_INIT;
                    end else begin
                        state_d = S_ABORT;
                    end
                end
                S_GAP: begin
                    if (bus.byte_req_i) begin
                        byte_vld_d  = 1'b1;
                        byte_d      = HDLC_FLAG;
                        byte_flag_d = 1'b1;
                        gap_d       = gap_q - GW'(1'b1);
                        state_d     = (gap_q <= GW'(1'b1)) ? S_IDLE : S_GAP;
                    end else begin
                        state_d = S_GAP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        frame_d      = (state_d == S_DATA) || (state_d == S_FCS);
        abortframe_d = (state_d == S_ABORT);
        busy_d       = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            byte_q       <= 8'h00;
            byte_vld_q   <= 1'b0;
            byte_flag_q  <= 1'b0;
            frame_q      <= 1'b0;
            abortframe_q <= 1'b0;
            txdone_q     <= 1'b0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            byte_q       <= byte_d;
            byte_vld_q   <= byte_vld_d;
            byte_flag_q  <= byte_flag_d;
            frame_q      <= frame_d;
            abortframe_q <= abortframe_d;
            txdone_q     <= txdone_d;
            aborted_q    <= aborted_d;
            busy_q       <= busy_d;
        end
    end

`ifdef HDLC_TX_CRC_EN
    // Tracks which FCS byte goes out next.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fcs_hi_q <= 1'b0;
        end else begin
            fcs_hi_q <= fcs_hi_d;
        end
    end
`endif

    assign bus.buf_ready_o  = buf_ready_s;
    assign bus.byte_o       = byte_q;
    assign bus.byte_vld_o   = byte_vld_q;
    assign bus.byte_flag_o  = byte_flag_q;
    assign bus.frame_o      = frame_q;
    assign bus.abortframe_o = abortframe_q;
    assign bus.txdone_o     = txdone_q;
    assign bus.aborted_o    = aborted_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: doc/hdlc_tx_ctrl.md
# hdlc_tx_ctrl

HDLC transmit frame controller on the `clk_i` domain, between the host byte buffer and the bit-level serializer. The serializer does zero-bit insertion and asks for one byte at a time. On each request this block supplies the right byte: idle fill, opening flag, payload, FCS, closing flag, inter-frame flags, or the abort pattern. It also drives the `frame`, `abortframe` and `txdone` status used across the HDLC core.

## Interface
- `MAX_LEN`, 256: maximum payload bytes per frame; `LW = $clog2(MAX_LEN+1)`.
- `GAP_FLAGS`, 1: number of extra 0x7E flags sent after a closing flag or abort, before returning to idle.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `txen_i`  in  1  transmitter enable.
- `start_i`  in  1  host pulse: start a frame.
- `len_i`  in  LW  payload byte count, latched when `start_i` is accepted.
- `abort_i`  in  1  host pulse: abort the current frame.
- `buf_data_i`  in  8  payload byte from the buffer.
- `buf_valid_i`  in  1  buffer has a byte.
- `buf_ready_o`  out  1  byte consumed this cycle.
- `byte_req_i`  in  1  serializer requests the next byte (one-cycle pulse).
- `byte_o`  out  8  byte to the serializer.
- `byte_vld_o`  out  1  `byte_o` valid (one-cycle pulse).
- `byte_flag_o`  out  1  byte must be sent without bit stuffing.
- `frame_o`  out  1  frame body in progress.
- `abortframe_o`  out  1  abort pending or being issued.
- `txdone_o`  out  1  pulse: closing flag issued.
- `aborted_o`  out  1  pulse: abort pattern issued.
- `busy_o`  out  1  state is not IDLE.

## Operation
- States: IDLE, OPEN, DATA, FCS, CLOSE, ABORT, GAP.
- **IDLE**
  - A request returns 0x7E if `txen_i` is high, otherwise 0xFF (mark). `byte_flag_o` = 1 in both cases.
  - Go to OPEN when `start_i & txen_i & len_i != 0 & len_i <= MAX_LEN & !abort_i`. Latch `len_i` into `cnt`.
  - Otherwise `start_i` is ignored.
- **OPEN**: request returns 0x7E with flag = 1, then go to DATA.
- **DATA**
  - On a request with `buf_valid_i` high: `buf_ready_o = 1` in the same cycle (combinational). Send `buf_data_i` with flag = 0, and decrement `cnt`.
  - When `cnt` reaches 0, go to FCS (CRC builds) or CLOSE.
  - A request with `buf_valid_i` low is an underrun: go to ABORT. No byte is consumed, and the request is answered from ABORT.
- **FCS**
  - Two requests return `~crc[7:0]`, then `~crc[15:8]`, both with flag = 0.
  - Then go to CLOSE.
- **CLOSE**: request returns 0x7E with flag = 1. Pulse `txdone_o` with `byte_vld_o`, then go to GAP.
- **ABORT**
  - Request returns 0xFF with flag = 1, giving 8 unstuffed ones.
  - Pulse `aborted_o`, then go to GAP.
- **GAP**
  - Each request returns 0x7E with flag = 1 and decrements the gap counter, which was loaded with `GAP_FLAGS` on entry.
  - At 0, go to IDLE. With `GAP_FLAGS` = 0, go directly to IDLE.
- **Abort triggers**
  - `abort_i`, or `txen_i` low, while in OPEN/DATA/FCS: go to ABORT on the next edge.
  - Ignored in IDLE, CLOSE, ABORT and GAP.
  - `abort_i` together with `start_i` in IDLE: no frame starts.
- **Outputs**
  - `frame_o` = state is DATA or FCS.
  - `abortframe_o` = state is ABORT.
  - `busy_o` = state is not IDLE.
  - All are registered.

## Timing
- `byte_vld_o` is asserted exactly 1 cycle after `byte_req_i`, with `byte_o`/`byte_flag_o` stable in that cycle. Back-to-back requests (every cycle) are supported.
- A state transition happens on the request edge.
- An abort trigger coincident with `byte_req_i` in DATA: that request returns 0xFF abort, and no buffer byte is consumed.
- Reset values:
  - state IDLE.
  - `byte_o` 0x00.
  - All 1-bit outputs 0.
  - `cnt` 0, gap counter 0, CRC 0xFFFF.
- Reset mid-frame leaves no partial output beyond the current cycle.
- `cnt` is LW bits wide and never wraps, because the len = 0 and len > MAX_LEN checks reject those values.

## Configuration
- `HDLC_TX_CRC_EN`
  - Defined: FCS state present. CRC-16/X.25 (reflected poly 0x8408, init 0xFFFF) runs over the payload bytes, reinitialised on entry to OPEN. The complemented value is sent low byte first.
  - Undefined: no CRC logic; DATA goes directly to CLOSE.

## Structure
- `hdlc_pkg`:
  - state enum `hdlc_tx_state_e`.
  - `HDLC_FLAG` = 8'h7E, `HDLC_ABORT` = 8'hFF.
  - `CRC16_POLY` = 16'h8408, `CRC16_INIT` = 16'hFFFF.
- Sub-module `hdlc_crc16`: a byte-wide combinational/registered CRC update with `init`/`en` inputs, instantiated only under `HDLC_TX_CRC_EN`.

## Test plan
- Idle fill: reset, then 3 requests with `txen_i` = 1 → 0x7E ×3, flag = 1. Same with `txen_i` = 0 → 0xFF ×3.
- Normal frame (CRC on), "123456789", `GAP_FLAGS` = 1:
  - Byte sequence: 7E, 31..39, 6E, 90, 7E, 7E.
  - `frame_o` high across the payload and FCS.
  - `txdone_o` pulses with the closing 7E; `buf_ready_o` pulses exactly 9 times.
- Underrun: len = 4, `buf_valid_i` dropped before the 3rd byte → 3rd response is 0xFF with flag = 1, `aborted_o` pulses, then 7E, then IDLE. `txdone_o` never pulses.
- Host abort: `abort_i` in DATA after 2 of 10 bytes → `abortframe_o` high until the next request, which returns FF. 8 bytes remain in the buffer (not consumed).
- Rejected starts: len = 0, len = 257, `start_i` with `txen_i` = 0, and `start_i` + `abort_i` together → `busy_o` stays 0 and idle fill continues.
- CRC off (macro undefined), len = 2 with 0xAA, 0x55 → 7E, AA, 55, 7E.
- Mid-frame reset: `rst_n_i` low → all outputs 0 asynchronously. The next request returns 7E.
